dbg_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver/transmitter and the MIPS pipeline. Decodes host command bytes, assembles 4-byte instruction words, and writes them into instruction memory. Gates the CPU clock-enable for continuous or single-step execution and returns a one-byte status over the UART transmitter. Sits in top between the uart rx/tx pair and the cpu/imem.

---
 rtl/dbg_cmd_ctrl_pkg.sv | 25 ++
 rtl/dbg_cmd_ctrl_word_assembler.sv | 36 +++
 rtl/dbg_cmd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dbg_cmd_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_cmd_ctrl_pkg.sv
// Shared definitions for the debug command sequencer: host command codes,
// status bytes returned to the host, and the sequencer state encoding.
package dbg_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    localparam logic [7:0] ST_ACK_LOAD = 8'hA1;
    localparam logic [7:0] ST_ACK_RUN  = 8'hA2;
    localparam logic [7:0] ST_ACK_STEP = 8'hA3;
    localparam logic [7:0] ST_OVERFLOW = 8'hE1;
    localparam logic [7:0] ST_UNKNOWN  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RUN     = 3'd3,
        S_STEP    = 3'd4,
        S_RESP    = 3'd5,
        S_WAIT_TX = 3'd6
    } state_e;

endpackage

// File: rtl/dbg_cmd_ctrl_word_assembler.sv
// Collects four bytes MSB-first into one instruction word; the completed word
// is presented combinationally alongside the fourth byte.
module word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_byte_vld,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_vld
);

    // Only the three oldest bytes need storage; the newest comes straight from the input.
    logic [DATA_W-9:0] word_r;
    logic [1:0]        count_r;

    assign o_word     = {word_r, i_byte};
    assign o_word_vld = i_byte_vld && (count_r == 2'd3);

    // Shift register and byte counter.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            word_r  <= '0;
            count_r <= 2'd0;
        end else if (i_clr) begin
            word_r  <= '0;
            count_r <= 2'd0;
        end else if (i_byte_vld) begin
            word_r  <= o_word[DATA_W-9:0];
            count_r <= count_r + 2'd1;
        end
    end

endmodule

// File: rtl/dbg_cmd_ctrl.sv
// Debug command sequencer: decodes host bytes, loads instruction memory,
// gates the CPU for run/step and reports a status byte over the UART.
module dbg_cmd_ctrl
    import dbg_pkg::*;
#(
    parameter int                IMEM_ADDR_W = 8,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_done,
    input  logic                   i_tx_done,
    input  logic                   i_cpu_halted,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0]      o_imem_wdata,
    output logic                   o_cpu_en,
    output logic                   o_cpu_rst,
    output logic                   o_busy
);

    localparam logic [IMEM_ADDR_W-1:0] ADDR_MAX = {IMEM_ADDR_W{1'b1}};

    state_e                 state_r, state_next_s;
    logic [IMEM_ADDR_W-1:0] addr_r, addr_next_s;
    logic [DATA_W-1:0]      wdata_r, wdata_next_s;
    logic [7:0]             status_r, status_next_s;
    logic                   tx_start_r, tx_start_next_s;
    logic                   we_r, we_next_s;
    logic                   cpu_en_r, cpu_en_next_s;
    logic                   cpu_rst_r, cpu_rst_next_s;
    logic                   busy_r;
    logic                   clr_s;
    logic                   byte_vld_s;
    logic [DATA_W-1:0]      word_s;
    logic                   word_vld_s;

    assign byte_vld_s = i_rx_done && (state_r == S_LOAD);

    word_assembler #(.DATA_W(DATA_W)) u_word_asm (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_clr      (clr_s),
        .i_byte_vld (byte_vld_s),
        .i_byte     (i_rx_data),
        .o_word     (word_s),
        .o_word_vld (word_vld_s)
    );

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_next_s    = state_r;
        addr_next_s     = addr_r;
        wdata_next_s    = wdata_r;
        status_next_s   = status_r;
        tx_start_next_s = 1'b0;
        we_next_s       = 1'b0;
        cpu_en_next_s   = 1'b0;
        cpu_rst_next_s  = 1'b0;
        clr_s           = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_next_s   = S_LOAD;
                            addr_next_s    = '0;
                            clr_s          = 1'b1;
                            cpu_rst_next_s = 1'b1;
                        end
                        CMD_RUN: begin
                            state_next_s  = S_RUN;
                            cpu_en_next_s = ~i_cpu_halted;
                        end
                        CMD_STEP: begin
                            state_next_s  = S_STEP;
                            cpu_en_next_s = 1'b1;
                        end
                        default: begin
                            state_next_s    = S_RESP;
                            status_next_s   = ST_UNKNOWN;
                            tx_start_next_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (word_vld_s) begin
                    state_next_s = S_WRITE;
                    we_next_s    = 1'b1;
                    wdata_next_s = word_s;
                    // CPU reset is released in the write cycle that terminates the load.
                    if ((word_s == HALT_WORD) || (addr_r == ADDR_MAX)) begin
                        cpu_rst_next_s = 1'b0;
                    end else begin
                        cpu_rst_next_s = 1'b1;
                    end
                end else begin
                    cpu_rst_next_s = 1'b1;
                end
            end
            S_WRITE: begin
                if (wdata_r == HALT_WORD) begin
                    state_next_s    = S_RESP;
                    status_next_s   = ST_ACK_LOAD;
                    tx_start_next_s = 1'b1;
                end else if (addr_r == ADDR_MAX) begin
                    state_next_s    = S_RESP;
                    status_next_s   = ST_OVERFLOW;
                    tx_start_next_s = 1'b1;
                end else begin
                    state_next_s   = S_LOAD;
                    addr_next_s    = addr_r + IMEM_ADDR_W'(1);
                    clr_s          = 1'b1;
                    cpu_rst_next_s = 1'b1;
                end
            end
            S_RUN: begin
                if (i_cpu_halted) begin
                    state_next_s    = S_RESP;
                    status_next_s   = ST_ACK_RUN;
                    tx_start_next_s = 1'b1;
                end else begin
                    cpu_en_next_s = 1'b1;
                end
            end
            S_STEP: begin
                state_next_s    = S_RESP;
                status_next_s   = ST_ACK_STEP;
                tx_start_next_s = 1'b1;
            end
            S_RESP: begin
                state_next_s = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT_TX;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, address and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r    <= S_IDLE;
            addr_r     <= '0;
            wdata_r    <= '0;
            status_r   <= 8'h00;
            tx_start_r <= 1'b0;
            we_r       <= 1'b0;
            cpu_en_r   <= 1'b0;
            cpu_rst_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            addr_r     <= addr_next_s;
            wdata_r    <= wdata_next_s;
            status_r   <= status_next_s;
            tx_start_r <= tx_start_next_s;
            we_r       <= we_next_s;
            cpu_en_r   <= cpu_en_next_s;
            cpu_rst_r  <= cpu_rst_next_s;
            busy_r     <= (state_next_s != S_IDLE);
        end
    end

    assign o_tx_data    = status_r;
    assign o_tx_start   = tx_start_r;
    assign o_imem_we    = we_r;
    assign o_imem_addr  = addr_r;
    assign o_imem_wdata = wdata_r;
    assign o_cpu_en     = cpu_en_r;
    assign o_cpu_rst    = cpu_rst_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Self-checking bench for dbg_cmd_ctrl with a small instruction memory so
// that overflow is reachable; expectations come from a command-level model.
module tb_dbg_cmd_ctrl;

    localparam int          AW   = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_done = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        i_cpu_halted = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_imem_we;
    logic [AW-1:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic        o_busy;

    dbg_cmd_ctrl #(.IMEM_ADDR_W(AW), .DATA_W(32), .HALT_WORD(HALT)) dut (
        .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .i_cpu_halted(i_cpu_halted), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata), .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Activity log gathered on falling edges.
    int en_cnt = 0;
    int wr_n = 0;
    int tx_n = 0;
    int overlap_n = 0;
    logic [AW-1:0] wr_addr_log [0:255];
    logic [31:0]   wr_data_log [0:255];

    always @(negedge clk) begin
        if (o_cpu_en === 1'b1) en_cnt++;
        if (o_imem_we === 1'b1) begin
            if (wr_n < 256) begin
                wr_addr_log[wr_n] = o_imem_addr;
                wr_data_log[wr_n] = o_imem_wdata;
            end
            wr_n++;
        end
        if (o_tx_start === 1'b1) tx_n++;
        if (o_cpu_en === 1'b1 && o_imem_we === 1'b1) overlap_n++;
    end

    logic [31:0] load_q [$];

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] got, output bit seen);
        seen = 1'b0;
        got  = 8'h00;
        if (o_tx_start === 1'b1) begin
            seen = 1'b1;
            got  = o_tx_data;
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (o_tx_start === 1'b1) begin
                seen = 1'b1;
                got  = o_tx_data;
            end
        end
    endtask

    task automatic finish_tx();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0000_0000;
        return w;
    endfunction

    // Sends a LOAD of load_q and checks writes, CPU reset, status byte and return to idle.
    task automatic run_load(input string name);
        int n_exp, base_wr, base_en, base_tx;
        logic [7:0] exp_st, got, bv;
        logic [31:0] w;
        bit seen, last;
        n_exp  = 0;
        exp_st = 8'h00;
        foreach (load_q[i]) begin
            n_exp++;
            if (load_q[i] == HALT) begin exp_st = 8'hA1; break; end
            if (i == (1 << AW) - 1) begin exp_st = 8'hE1; break; end
        end
        @(negedge clk); #1;
        base_wr = wr_n; base_en = en_cnt; base_tx = tx_n;
        send_byte(8'h01);
        checks++;
        if (o_cpu_rst !== 1'b1) begin
            errors++; $display("FAIL %s cpu_rst_start: got %b expected 1", name, o_cpu_rst);
        end
        for (int i = 0; i < n_exp; i++) begin
            w = load_q[i];
            for (int b = 3; b >= 0; b--) begin
                bv = w[b*8 +: 8];
                send_byte(bv);
                last = (i == n_exp - 1) && (b == 0);
                checks++;
                if (o_cpu_rst !== !last) begin
                    errors++;
                    $display("FAIL %s cpu_rst word%0d byte%0d: got %b expected %b", name, i, b, o_cpu_rst, !last);
                end
            end
        end
        wait_tx(got, seen);
        checks++;
        if (!seen || got !== exp_st) begin
            errors++; $display("FAIL %s status: got %h (seen %0d) expected %h", name, got, seen, exp_st);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_tx_data !== exp_st) begin
            errors++; $display("FAIL %s wait_tx_hold: busy %b data %h expected busy 1 data %h", name, o_busy, o_tx_data, exp_st);
        end
        finish_tx();
        checks++;
        if (o_busy !== 1'b0 || o_cpu_rst !== 1'b0) begin
            errors++; $display("FAIL %s idle: busy %b cpu_rst %b expected 0 0", name, o_busy, o_cpu_rst);
        end
        #1;
        checks++;
        if (wr_n - base_wr != n_exp || tx_n - base_tx != 1 || en_cnt != base_en) begin
            errors++;
            $display("FAIL %s counts: writes %0d tx %0d en %0d expected %0d 1 0", name, wr_n - base_wr, tx_n - base_tx, en_cnt - base_en, n_exp);
        end
        for (int i = 0; i < n_exp && base_wr + i < wr_n; i++) begin
            checks++;
            if (wr_addr_log[base_wr + i] !== AW'(i) || wr_data_log[base_wr + i] !== load_q[i]) begin
                errors++;
                $display("FAIL %s write%0d: got %h@%0d expected %h@%0d", name, i, wr_data_log[base_wr + i], wr_addr_log[base_wr + i], load_q[i], i);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx %h %b we %b addr %h wd %h en %b rst %b busy %b expected all 0",
                     o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst, o_busy);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_load_single();
        load_q = '{32'h2001_000F, HALT};
        run_load("load_single");
    endtask

    task automatic test_run(input int n);
        int base_en;
        logic [7:0] got;
        bit seen;
        @(negedge clk); #1;
        base_en = en_cnt;
        send_byte(8'h02);
        checks++;
        if (o_cpu_en !== 1'b1) begin
            errors++; $display("FAIL run_latency: cpu_en %b expected 1", o_cpu_en);
        end
        repeat (n - 1) @(negedge clk);
        i_cpu_halted = 1'b1;
        wait_tx(got, seen);
        #1;
        checks++;
        if (!seen || got !== 8'hA2 || en_cnt - base_en != n) begin
            errors++; $display("FAIL run_%0d: status %h seen %0d en cycles %0d expected A2 and %0d", n, got, seen, en_cnt - base_en, n);
        end
        finish_tx();
        checks++;
        if (o_busy !== 1'b0 || o_cpu_en !== 1'b0) begin
            errors++; $display("FAIL run_idle: busy %b en %b expected 0 0", o_busy, o_cpu_en);
        end
        i_cpu_halted = 1'b0;
    endtask

    task automatic test_run_halted();
        int base_en;
        logic [7:0] got;
        bit seen;
        i_cpu_halted = 1'b1;
        @(negedge clk); #1;
        base_en = en_cnt;
        send_byte(8'h02);
        wait_tx(got, seen);
        #1;
        checks++;
        if (!seen || got !== 8'hA2 || en_cnt != base_en) begin
            errors++; $display("FAIL run_halted: status %h seen %0d en cycles %0d expected A2 and 0", got, seen, en_cnt - base_en);
        end
        finish_tx();
        i_cpu_halted = 1'b0;
    endtask

    task automatic test_step();
        int base_en;
        logic [7:0] got;
        bit seen;
        @(negedge clk); #1;
        base_en = en_cnt;
        send_byte(8'h03);
        checks++;
        if (o_cpu_en !== 1'b1) begin
            errors++; $display("FAIL step_latency: cpu_en %b expected 1", o_cpu_en);
        end
        wait_tx(got, seen);
        #1;
        checks++;
        if (!seen || got !== 8'hA3 || en_cnt - base_en != 1) begin
            errors++; $display("FAIL step: status %h seen %0d en cycles %0d expected A3 and 1", got, seen, en_cnt - base_en);
        end
        finish_tx();
    endtask

    task automatic test_unknown(input logic [7:0] cmd);
        int base_en, base_wr, base_tx;
        logic [7:0] got;
        bit seen;
        @(negedge clk); #1;
        base_en = en_cnt; base_wr = wr_n; base_tx = tx_n;
        send_byte(cmd);
        wait_tx(got, seen);
        checks++;
        if (!seen || got !== 8'hEE) begin
            errors++; $display("FAIL unknown_%h: status %h seen %0d expected EE", cmd, got, seen);
        end
        send_byte(8'h02);
        finish_tx();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || en_cnt != base_en || wr_n != base_wr || tx_n - base_tx != 1) begin
            errors++;
            $display("FAIL unknown_drop: busy %b en %0d wr %0d tx %0d expected 0 0 0 1", o_busy, en_cnt - base_en, wr_n - base_wr, tx_n - base_tx);
        end
    endtask

    task automatic test_overflow();
        load_q.delete();
        for (int i = 0; i < 4; i++) load_q.push_back(rand_word());
        run_load("overflow");
    endtask

    task automatic test_reset_mid_load();
        int base_tx;
        @(negedge clk); #1;
        base_tx = tx_n;
        send_byte(8'h01);
        send_word(rand_word());
        send_byte(8'h5A);
        send_byte(8'hC3);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        checks++;
        if ({o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst, o_busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: tx %h we %b addr %h wd %h en %b rst %b busy %b expected all 0",
                     o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst, o_busy);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (tx_n != base_tx) begin
            errors++; $display("FAIL mid_reset_tx: tx pulses %0d expected 0", tx_n - base_tx);
        end
        load_q = '{rand_word(), HALT};
        run_load("after_reset");
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
    endtask

    task automatic test_back_to_back();
        int k;
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(0, 4);
            load_q.delete();
            for (int i = 0; i <= k; i++) load_q.push_back((i == k && k < 4) ? HALT : rand_word());
            run_load($sformatf("rand_load%0d", it));
            if ($urandom_range(0, 1) == 1) test_step();
            else test_run($urandom_range(1, 9));
        end
    endtask

    initial begin
        test_reset();
        test_load_single();
        test_run(20);
        test_step();
        test_unknown(8'h55);
        test_unknown(8'($urandom_range(4, 255)));
        test_run_halted();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        checks++;
        if (overlap_n != 0) begin
            errors++; $display("FAIL en_we_overlap: got %0d cycles expected 0", overlap_n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
